// File: rtl/pixel_frame_writer.sv
// Pixel frame writer: streams decoded 3-bit pixels into the frame buffer write port,
// with frame completion, bulk clear and optional bank ping-pong (PFW_DOUBLE_BUFFER_EN).
module pixel_frame_writer #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        pixel_data,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    input  logic              clear_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [2:0]        mem_wdata,
    output logic              mem_wbank,
    output logic              disp_bank,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              busy
);

    localparam int PIXELS = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        SWAP  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [2:0]        wdata_d;
    logic              done_d;
    logic [7:0]        count_d;
    logic              busy_d;

    assign pixel_ready = (state == RECV);

`ifdef PFW_DOUBLE_BUFFER_EN
    logic bank_q, bank_d;

    // A single bank bit keeps the write and display banks complementary by construction.
    assign mem_wbank = bank_q;
    assign disp_bank = ~bank_q;
`else
    assign mem_wbank = 1'b0;
    assign disp_bank = 1'b0;
`endif

    always_comb begin
        state_d = state;
        addr_d  = addr;
        we_d    = 1'b0;
        waddr_d = mem_waddr;
        wdata_d = mem_wdata;
        done_d  = 1'b0;
        count_d = frame_count;
        busy_d  = 1'b0;
`ifdef PFW_DOUBLE_BUFFER_EN
        bank_d  = bank_q;
`endif
        case (state)
            RECV: begin
                if (clear_req) begin
                    // First clear write (address 0) issues on the same edge that leaves RECV.
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = '0;
                    busy_d  = 1'b1;
                    addr_d  = ADDR_W'(1);
                end else if (pixel_valid) begin
                    we_d    = 1'b1;
                    waddr_d = addr;
                    wdata_d = pixel_data;
                    if (addr == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = SWAP;
                    end else begin
                        addr_d = addr + ADDR_W'(1);
                    end
                end
            end
            SWAP: begin
                done_d  = 1'b1;
                count_d = frame_count + 8'd1;
`ifdef PFW_DOUBLE_BUFFER_EN
                bank_d  = ~bank_q;
`endif
                state_d = RECV;
            end
            CLEAR: begin
                if (mem_waddr == LAST_ADDR) begin
                    state_d = RECV;
                    addr_d  = '0;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = addr;
                    wdata_d = '0;
                    busy_d  = 1'b1;
                    addr_d  = addr + ADDR_W'(1);
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RECV;
            addr        <= '0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
`ifdef PFW_DOUBLE_BUFFER_EN
            bank_q      <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            addr        <= addr_d;
            mem_we      <= we_d;
            mem_waddr   <= waddr_d;
            mem_wdata   <= wdata_d;
            frame_done  <= done_d;
            frame_count <= count_d;
            busy        <= busy_d;
`ifdef PFW_DOUBLE_BUFFER_EN
            bank_q      <= bank_d;
`endif
        end
    end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed testbench for pixel_frame_writer on a reduced 16x8 frame;
// bank expectations follow PFW_DOUBLE_BUFFER_EN.
module tb_pixel_frame_writer;

    localparam int IMG_W  = 16;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = 7;
    localparam int P      = IMG_W * IMG_H;
`ifdef PFW_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [2:0]        pixel_data = '0;
    logic              pixel_valid = 1'b0;
    logic              pixel_ready;
    logic              clear_req = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [2:0]        mem_wdata;
    logic              mem_wbank;
    logic              disp_bank;
    logic              frame_done;
    logic [7:0]        frame_count;
    logic              busy;

    int vectors = 0;
    int errors  = 0;

    pixel_frame_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .clear_req(clear_req), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wbank(mem_wbank),
        .disp_bank(disp_bank), .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        vectors++; if (pixel_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b expected 1", tag, pixel_ready); end
        vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s we: got %b expected 0", tag, mem_we); end
        vectors++; if (mem_waddr !== '0) begin errors++; $display("FAIL %s waddr: got %0d expected 0", tag, mem_waddr); end
        vectors++; if (mem_wdata !== 3'd0) begin errors++; $display("FAIL %s wdata: got %0d expected 0", tag, mem_wdata); end
        vectors++; if (mem_wbank !== 1'b0) begin errors++; $display("FAIL %s wbank: got %b expected 0", tag, mem_wbank); end
        vectors++; if (disp_bank !== DB) begin errors++; $display("FAIL %s disp_bank: got %b expected %b", tag, disp_bank, DB); end
        vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL %s frame_done: got %b expected 0", tag, frame_done); end
        vectors++; if (frame_count !== 8'd0) begin errors++; $display("FAIL %s frame_count: got %0d expected 0", tag, frame_count); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", tag, busy); end
    endtask

    task automatic check_banks(input string tag, input int frames);
        logic wb;
        wb = DB & frames[0];
        vectors++; if (mem_wbank !== wb) begin errors++; $display("FAIL %s wbank: got %b expected %b", tag, mem_wbank, wb); end
        vectors++; if (disp_bank !== (DB & ~wb)) begin errors++; $display("FAIL %s disp_bank: got %b expected %b", tag, disp_bank, DB & ~wb); end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < P; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = 3'(i % 8);
            vectors++; if (pixel_ready !== 1'b1) begin errors++; $display("FAIL frame_ready[%0d]: got %b expected 1", i, pixel_ready); end
            tick();
            vectors++; if (mem_we !== 1'b1 || mem_waddr !== 7'(i) || mem_wdata !== 3'(i % 8))
                begin errors++; $display("FAIL frame_write[%0d]: got we=%b a=%0d d=%0d expected we=1 a=%0d d=%0d", i, mem_we, mem_waddr, mem_wdata, i, i % 8); end
            vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_early[%0d]: got %b expected 0", i, frame_done); end
        end
        pixel_valid = 1'b0;
        vectors++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL swap_ready: got %b expected 0", pixel_ready); end
        tick();
        vectors++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done: got %b expected 1", frame_done); end
        vectors++; if (frame_count !== 8'd1) begin errors++; $display("FAIL frame_count1: got %0d expected 1", frame_count); end
        vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL swap_we: got %b expected 0", mem_we); end
        check_banks("frame1", 1);
        tick();
        vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse: got %b expected 0", frame_done); end
        vectors++; if (pixel_ready !== 1'b1) begin errors++; $display("FAIL ready_after_swap: got %b expected 1", pixel_ready); end
    endtask

    task automatic test_back_to_back();
        int low_cycles;
        low_cycles = 0;
        pixel_valid = 1'b1;
        for (int i = 0; i < P; i++) begin
            pixel_data = 3'((i * 3) % 8);
            tick();
            vectors++; if (mem_we !== 1'b1 || mem_waddr !== 7'(i) || mem_wdata !== 3'((i * 3) % 8))
                begin errors++; $display("FAIL b2b_write[%0d]: got we=%b a=%0d d=%0d expected a=%0d d=%0d", i, mem_we, mem_waddr, mem_wdata, i, (i * 3) % 8); end
        end
        pixel_data = 3'd5;
        if (pixel_ready !== 1'b1) low_cycles++;
        tick();
        vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bubble_we: got %b expected 0", mem_we); end
        vectors++; if (frame_done !== 1'b1 || frame_count !== 8'd2) begin errors++; $display("FAIL bubble_done: got done=%b count=%0d expected done=1 count=2", frame_done, frame_count); end
        check_banks("frame2", 2);
        if (pixel_ready !== 1'b1) low_cycles++;
        tick();
        vectors++; if (low_cycles !== 1) begin errors++; $display("FAIL bubble_len: got %0d expected 1", low_cycles); end
        vectors++; if (mem_we !== 1'b1 || mem_waddr !== 7'd0 || mem_wdata !== 3'd5)
            begin errors++; $display("FAIL bubble_next: got we=%b a=%0d d=%0d expected we=1 a=0 d=5", mem_we, mem_waddr, mem_wdata); end
        pixel_valid = 1'b0;
    endtask

    // Frame 3 already holds address 0 from the previous test; 100 more pixels go to 1..100.
    task automatic test_clear_mid_frame();
        pixel_valid = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            pixel_data = 3'(i % 8);
            tick();
            vectors++; if (mem_we !== 1'b1 || mem_waddr !== 7'(i)) begin errors++; $display("FAIL pre_clear_write[%0d]: got we=%b a=%0d expected we=1 a=%0d", i, mem_we, mem_waddr, i); end
        end
        pixel_data = 3'd7;
        clear_req  = 1'b1;
        tick();
        clear_req   = 1'b0;
        pixel_valid = 1'b0;
        for (int j = 0; j < P; j++) begin
            vectors++; if (busy !== 1'b1 || mem_we !== 1'b1 || mem_waddr !== 7'(j) || mem_wdata !== 3'd0)
                begin errors++; $display("FAIL clear_write[%0d]: got busy=%b we=%b a=%0d d=%0d expected busy=1 we=1 a=%0d d=0", j, busy, mem_we, mem_waddr, mem_wdata, j); end
            vectors++; if (pixel_ready !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL clear_flags[%0d]: got ready=%b done=%b expected 0 0", j, pixel_ready, frame_done); end
            clear_req   = (j == 10);
            pixel_valid = (j == 20);
            tick();
        end
        clear_req   = 1'b0;
        pixel_valid = 1'b0;
        vectors++; if (busy !== 1'b0 || mem_we !== 1'b0 || pixel_ready !== 1'b1)
            begin errors++; $display("FAIL clear_end: got busy=%b we=%b ready=%b expected 0 0 1", busy, mem_we, pixel_ready); end
        vectors++; if (frame_count !== 8'd2) begin errors++; $display("FAIL clear_count: got %0d expected 2", frame_count); end
        check_banks("after_clear", 2);
    endtask

    task automatic test_gapped();
        int writes;
        writes = 0;
        for (int k = 0; k < 20; k++) begin
            pixel_valid = (k % 2 == 0);
            pixel_data  = 3'((k / 2 + 1) % 8);
            tick();
            if (mem_we === 1'b1) writes++;
            if (k % 2 == 0) begin
                vectors++; if (mem_we !== 1'b1 || mem_waddr !== 7'(k / 2) || mem_wdata !== 3'((k / 2 + 1) % 8))
                    begin errors++; $display("FAIL gap_write[%0d]: got we=%b a=%0d d=%0d expected we=1 a=%0d d=%0d", k, mem_we, mem_waddr, mem_wdata, k / 2, (k / 2 + 1) % 8); end
            end else begin
                vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL gap_idle[%0d]: got we=%b expected 0", k, mem_we); end
            end
        end
        pixel_valid = 1'b0;
        vectors++; if (writes !== 10) begin errors++; $display("FAIL gap_count: got %0d expected 10", writes); end
    endtask

    task automatic test_reset_mid_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (20) tick();
        vectors++; if (busy !== 1'b1 || mem_waddr !== 7'd20) begin errors++; $display("FAIL mid_clear: got busy=%b a=%0d expected busy=1 a=20", busy, mem_waddr); end
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_mid_clear");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_values("after_mid_clear_reset");
    endtask

    task automatic test_counter_wrap();
        int pulses;
        pulses = 0;
        pixel_valid = 1'b1;
        for (int c = 0; c < 256 * (P + 1); c++) begin
            pixel_data = 3'(c % 8);
            tick();
            if (frame_done === 1'b1) begin
                pulses++;
                if (pulses == 255) begin
                    vectors++; if (frame_count !== 8'd255) begin errors++; $display("FAIL count_255: got %0d expected 255", frame_count); end
                end
            end
        end
        pixel_valid = 1'b0;
        vectors++; if (pulses !== 256) begin errors++; $display("FAIL wrap_pulses: got %0d expected 256", pulses); end
        vectors++; if (frame_count !== 8'd0) begin errors++; $display("FAIL count_wrap: got %0d expected 0", frame_count); end
        check_banks("wrap", 256);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_clear_mid_frame();
        test_gapped();
        test_reset_mid_clear();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pixel_frame_writer.md
# pixel_frame_writer

Downstream of the base64 decoder: accepts decoded 3-bit pixels over a valid/ready handshake and writes them sequentially into the frame buffer RAM's write port. It tracks the raster address, signals frame completion, and supports a bulk clear. Optionally it ping-pongs between two frame banks so the display side always reads a complete frame.

## Interface
- `IMG_W`, default 128: image width in pixels.
- `IMG_H`, default 64: image height in pixels.
- `ADDR_W`, default 13: RAM address width; `IMG_W*IMG_H` must not exceed `2**ADDR_W`.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pixel_data`  in  3  decoded pixel.
- `pixel_valid`  in  1  upstream pixel available.
- `pixel_ready`  out  1  writer accepts a pixel this cycle.
- `clear_req`  in  1  single-cycle request to zero the write bank.
- `mem_we`  out  1  RAM write enable.
- `mem_waddr`  out  ADDR_W  RAM write address.
- `mem_wdata`  out  3  RAM write data.
- `mem_wbank`  out  1  bank being written.
- `disp_bank`  out  1  bank the display must read.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is written.
- `frame_count`  out  8  completed frames, wraps 255→0.
- `busy`  out  1  high while in CLEAR.

## Operation
- `PIXELS = IMG_W*IMG_H`. Internal address counter `addr` runs 0..PIXELS-1.
- Reset values: state RECV, `addr`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `mem_wbank`=0, `disp_bank`=1 when double buffering is enabled and 0 otherwise, `frame_done`=0, `frame_count`=0, `busy`=0.
- `pixel_ready` = (state==RECV). It is decoded from the state register only, never from `pixel_valid`.
- **RECV state**
  - Handshake (`pixel_valid && pixel_ready`): register `mem_we`=1, `mem_waddr`=`addr`, `mem_wdata`=`pixel_data`.
  - If `addr`==PIXELS-1, set `addr` to 0 and go to SWAP. Otherwise increment `addr`.
  - No handshake: `mem_we`=0; address and data hold.
- **SWAP state** (exactly 1 cycle)
  - `frame_done`=1 and `frame_count` increments.
  - If double buffering is enabled, toggle both `mem_wbank` and `disp_bank`.
  - Return to RECV.
- **CLEAR state**
  - Write 0 to every address 0..PIXELS-1 of `mem_wbank`, one per cycle (`mem_we`=1).
  - After the write to PIXELS-1, go to RECV with `addr`=0.
  - No `frame_done`, no bank swap, no count change.
- `clear_req` is honoured only in RECV. It has priority over a simultaneous handshake: that pixel is discarded and no write is issued for it. The partial frame is abandoned and `addr` is set to 0.
- `clear_req` in CLEAR or SWAP is ignored.
- An asynchronous reset in any state (including mid-clear or mid-frame) immediately forces all reset values.

## Timing
- Write latency: `mem_we`, `mem_waddr` and `mem_wdata` are valid 1 cycle after the accepting edge.
- Back-to-back pixels: sustained rate is 1 pixel per cycle within a frame.
- Frame boundary bubble: `pixel_ready` is low for exactly 1 cycle (SWAP) after the last pixel is accepted.
- `frame_done` rises 1 cycle after the final pixel's `mem_we` cycle. At that point the bank swap is already visible on `mem_wbank` and `disp_bank`.
- Clear: `busy` and `mem_we` are high for exactly PIXELS cycles starting the cycle after `clear_req`. `pixel_ready` is low throughout, and the first clear write is to address 0.

## Configuration
- `PFW_DOUBLE_BUFFER_EN` defined:
  - Two banks. `mem_wbank` and `disp_bank` always differ and toggle in SWAP.
- Undefined:
  - `mem_wbank` and `disp_bank` are tied to 0. SWAP only pulses `frame_done` and increments `frame_count`.

## Test plan
- **Single frame.** Reset, then stream PIXELS pixels with `pixel_data`=addr%8 at 1 per cycle.
  - Expect writes to addresses 0..PIXELS-1 with matching data.
  - Expect one `frame_done` pulse and `frame_count`=1.
  - With the macro defined: `mem_wbank`=1, `disp_bank`=0. With it undefined: both 0.
- **Backpressure bubble.** Keep `pixel_valid` high across a frame boundary.
  - `pixel_ready` is low for exactly 1 cycle.
  - The next pixel is written to address 0.
- **Gapped input.** Toggle `pixel_valid` every other cycle for 10 pixels.
  - Exactly 10 writes occur, to addresses 0..9.
  - `mem_we` is low on idle cycles.
- **Clear mid-frame.** Accept 100 pixels, then assert `clear_req` together with a valid pixel.
  - The pixel is discarded.
  - PIXELS zero-writes follow, 0..PIXELS-1, with `busy` high and no `frame_done`.
  - The next pixel is written to address 0.
- **Reset mid-clear, and counter wrap.**
  - Assert `rst_n`=0 during CLEAR: all outputs return to reset values immediately.
  - Run 256 frames: `frame_count` wraps to 0.
